// File: rtl/mc_ctrl_stall.sv
// Multicycle MIPS control FSM with a variable-latency memory handshake,
// a wait timeout into a sticky error state, illegal-opcode reporting and state visibility.
module mc_ctrl_stall #(
    parameter int HANDSHAKE = 1,
    parameter int TIMEOUT   = 64,
    parameter int TO_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ALUSrcA,
    output logic       ShiftSel,
    output logic [1:0] ALUSrcB,
    output logic       ExtSel,
    output logic [3:0] ALUControl,
    output logic       IorD,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCEn,
    output logic       MemWrite,
    output logic       PCPlus4Write,
    output logic       busy,
    output logic       illegal,
    output logic       err,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB   = 4'd7,
        S_IEX    = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13, S_ERR    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD  = 4'd2, ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4, ALU_SLL = 4'd5, ALU_SUB  = 4'd6, ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_SLTU = 4'd10, ALU_LUI = 4'd11;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          state, next;
    logic [TO_W-1:0] to_cnt;
    logic            ready, adv, waiting, timeout_hit;
    logic [3:0]      rex_alu;
    logic            rex_shift, rex_legal;

    assign ready       = (HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign adv         = clk_en & ~rst;
    assign waiting     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST) && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            to_cnt <= '0;
        end else if (clk_en) begin
            state <= next;
            if (waiting && !ready && !timeout_hit) to_cnt <= to_cnt + TO_W'(1);
            else                                   to_cnt <= '0;
        end
    end

    always_comb begin
        rex_alu   = ALU_ADD;
        rex_shift = 1'b0;
        rex_legal = 1'b1;
        case (funct)
            6'h00:        begin rex_alu = ALU_SLL; rex_shift = 1'b1; end
            6'h02:        begin rex_alu = ALU_SRL; rex_shift = 1'b1; end
            6'h03:        begin rex_alu = ALU_SRA; rex_shift = 1'b1; end
            6'h20, 6'h21: rex_alu = ALU_ADD;
            6'h22, 6'h23: rex_alu = ALU_SUB;
            6'h24:        rex_alu = ALU_AND;
            6'h25:        rex_alu = ALU_OR;
            6'h26:        rex_alu = ALU_XOR;
            6'h27:        rex_alu = ALU_NOR;
            6'h2A:        rex_alu = ALU_SLT;
            6'h2B:        rex_alu = ALU_SLTU;
            default:      rex_legal = 1'b0;
        endcase
    end

    // Write enables are qualified by adv so a frozen or resetting cycle never commits.
    always_comb begin
        next         = state;
        mem_req      = 1'b0;
        ALUSrcA      = 1'b0;
        ShiftSel     = 1'b0;
        ALUSrcB      = 2'b00;
        ExtSel       = 1'b0;
        ALUControl   = ALU_AND;
        IorD         = 1'b0;
        MemtoReg     = 2'b00;
        RegDst       = 2'b00;
        PCSrc        = 2'b00;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        PCEn         = 1'b0;
        MemWrite     = 1'b0;
        PCPlus4Write = 1'b0;
        illegal      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                if (ready) begin
                    IRWrite      = adv;
                    PCEn         = adv;
                    PCPlus4Write = adv;
                    next         = S_DECODE;
                end else if (timeout_hit) begin
                    next = S_ERR;
                end
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:   next = S_MEMADR;
                    OP_RTYPE:       next = (funct == FN_JR) ? S_JR : S_REX;
                    OP_BEQ, OP_BNE: next = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI, OP_SLTIU, OP_LUI: next = S_IEX;
                    OP_J:           next = S_JUMP;
                    OP_JAL:         next = S_JAL;
                    default: begin
                        illegal = adv;
                        next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                next       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (ready)            next = S_MEMWB;
                else if (timeout_hit) next = S_ERR;
            end
            S_MEMWB: begin
                RegWrite = adv;
                MemtoReg = 2'b01;
                next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (ready) begin
                    MemWrite = adv;
                    next     = S_FETCH;
                end else if (timeout_hit) begin
                    next = S_ERR;
                end
            end
            S_REX: begin
                ALUSrcA    = 1'b1;
                ALUControl = rex_alu;
                ShiftSel   = rex_shift;
                if (rex_legal) begin
                    next = S_RWB;
                end else begin
                    illegal = adv;
                    next    = S_FETCH;
                end
            end
            S_RWB: begin
                RegWrite = adv;
                RegDst   = 2'b01;
                next     = S_FETCH;
            end
            S_IEX: begin
                ALUSrcB = 2'b10;
                ExtSel  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
                case (opcode)
                    OP_SLTI:  ALUControl = ALU_SLT;
                    OP_SLTIU: ALUControl = ALU_SLTU;
                    OP_ANDI:  ALUControl = ALU_AND;
                    OP_ORI:   ALUControl = ALU_OR;
                    OP_XORI:  ALUControl = ALU_XOR;
                    OP_LUI:   ALUControl = ALU_LUI;
                    default:  ALUControl = ALU_ADD;
                endcase
                next = S_IWB;
            end
            S_IWB: begin
                RegWrite = adv;
                next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCEn       = adv & ((opcode == OP_BNE) ? ~zero : zero);
                next       = S_FETCH;
            end
            S_JUMP: begin
                PCEn  = adv;
                PCSrc = 2'b10;
                next  = S_FETCH;
            end
            S_JAL: begin
                PCEn     = adv;
                PCSrc    = 2'b10;
                RegWrite = adv;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                next     = S_FETCH;
            end
            S_JR: begin
                PCEn  = adv;
                PCSrc = 2'b11;
                next  = S_FETCH;
            end
            S_ERR:   next = S_ERR;
            default: next = S_FETCH;
        endcase
        if (rst) mem_req = 1'b0;
    end

    assign busy      = (state != S_FETCH);
    assign err       = (state == S_ERR);
    assign state_dbg = state;

endmodule

// File: tb/tb_mc_ctrl_stall.sv
// Scoreboard bench for mc_ctrl_stall: each driven cycle queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_stall;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7;
    localparam logic [3:0] S_IEX = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;
    localparam logic [3:0] S_JAL = 4'd12, S_JR = 4'd13, S_ERR = 4'd14;

    // Enable vector order: {IRWrite, RegWrite, PCEn, MemWrite, PCPlus4Write}
    localparam logic [4:0] EN_NONE = 5'b00000, EN_FETCH = 5'b10101, EN_RW = 5'b01000;
    localparam logic [4:0] EN_PC = 5'b00100, EN_MW = 5'b00010, EN_JAL = 5'b01100;
    localparam logic [15:0] M_ALL = 16'hFFFF, M_NONE = 16'h0000;

    typedef struct packed {
        logic [3:0]  st;
        logic        req;
        logic [4:0]  en;
        logic        ill;
        logic        err;
        logic [15:0] sel;
        logic [15:0] mask;
    } exp_t;

    logic       clk = 1'b1;
    logic       rst, clk_en, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, ALUSrcA, ShiftSel, ExtSel, IorD;
    logic [1:0] ALUSrcB, MemtoReg, RegDst, PCSrc;
    logic [3:0] ALUControl, state_dbg;
    logic       IRWrite, RegWrite, PCEn, MemWrite, PCPlus4Write, busy, illegal, err;

    exp_t  sb[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [15:0] v_fetch, v_dec, m_dec, v_madr, m_madr, v_mem, v_mwb, v_rwb, v_iwb, m_wb;
    logic [15:0] v_br, m_br, v_jal, m_jal, v_jr, v_jmp, m_pc, v_add, v_sll, m_rex, v_ori, m_iex;

    mc_ctrl_stall #(.HANDSHAKE(1), .TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .ALUSrcA(ALUSrcA),
        .ShiftSel(ShiftSel), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUControl(ALUControl),
        .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .PCEn(PCEn), .MemWrite(MemWrite),
        .PCPlus4Write(PCPlus4Write), .busy(busy), .illegal(illegal), .err(err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk_sel(logic srca, logic shift, logic [1:0] srcb, logic ext,
                                           logic [3:0] aluc, logic iord, logic [1:0] m2r,
                                           logic [1:0] rdst, logic [1:0] pcs);
        return {srca, shift, srcb, ext, aluc, iord, m2r, rdst, pcs};
    endfunction

    function automatic exp_t ex(logic [3:0] st, logic req, logic [4:0] en, logic ill,
                                logic er, logic [15:0] val, logic [15:0] mask);
        exp_t e;
        e.st = st; e.req = req; e.en = en; e.ill = ill; e.err = er; e.sel = val; e.mask = mask;
        return e;
    endfunction

    task automatic apply_stimulus(input logic r, input logic ce, input logic rdy, input logic z,
                                  input logic [5:0] op, input logic [5:0] fn,
                                  input exp_t e, input string nm);
        rst = r; clk_en = ce; mem_ready = rdy; zero = z; opcode = op; funct = fn;
        sb.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input logic [5:0] op, input logic [5:0] fn, input string nm);
        apply_stimulus(0, 1, 1, 0, op, fn, ex(S_FETCH, 1, EN_FETCH, 0, 0, v_fetch, M_ALL), nm);
    endtask

    task automatic decode_ok(input logic [5:0] op, input logic [5:0] fn, input string nm);
        apply_stimulus(0, 1, 1, 0, op, fn, ex(S_DECODE, 0, EN_NONE, 0, 0, v_dec, m_dec), nm);
    endtask

    task automatic check_output(input exp_t e, input string nm);
        logic [4:0]  act_en;
        logic [15:0] act_sel;
        act_en  = {IRWrite, RegWrite, PCEn, MemWrite, PCPlus4Write};
        act_sel = mk_sel(ALUSrcA, ShiftSel, ALUSrcB, ExtSel, ALUControl, IorD, MemtoReg, RegDst, PCSrc);
        checks++;
        if (state_dbg !== e.st || mem_req !== e.req || act_en !== e.en || illegal !== e.ill ||
            err !== e.err || busy !== (e.st != S_FETCH) || (act_sel & e.mask) !== (e.sel & e.mask)) begin
            errors++;
            $display("[TB] FAIL %s: got st=%0d req=%b en=%b ill=%b err=%b busy=%b sel=%h; want st=%0d req=%b en=%b ill=%b err=%b sel=%h mask=%h",
                     nm, state_dbg, mem_req, act_en, illegal, err, busy, act_sel,
                     e.st, e.req, e.en, e.ill, e.err, e.sel, e.mask);
        end
    endtask

    // Monitor: compares one queued expectation per cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) check_output(sb.pop_front(), name_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0] br_op [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic       br_z  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] br_en [4] = '{EN_NONE, EN_PC, EN_PC, EN_NONE};

        v_fetch = mk_sel(0, 0, 2'b01, 0, 4'd2, 0, 2'b00, 2'b00, 2'b00);
        v_dec   = mk_sel(0, 0, 2'b11, 0, 4'd2, 0, 2'b00, 2'b00, 2'b00);
        m_dec   = mk_sel(0, 0, 2'b11, 0, 4'hF, 0, 2'b00, 2'b00, 2'b00);
        v_madr  = mk_sel(1, 0, 2'b10, 0, 4'd2, 0, 2'b00, 2'b00, 2'b00);
        m_madr  = mk_sel(1, 0, 2'b11, 1, 4'hF, 0, 2'b00, 2'b00, 2'b00);
        v_mem   = mk_sel(0, 0, 2'b00, 0, 4'd0, 1, 2'b00, 2'b00, 2'b00);
        v_mwb   = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b01, 2'b00, 2'b00);
        v_rwb   = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b00, 2'b01, 2'b00);
        v_iwb   = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b00, 2'b00, 2'b00);
        m_wb    = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b11, 2'b11, 2'b00);
        v_br    = mk_sel(1, 0, 2'b00, 0, 4'd6, 0, 2'b00, 2'b00, 2'b01);
        m_br    = mk_sel(1, 0, 2'b11, 0, 4'hF, 0, 2'b00, 2'b00, 2'b11);
        v_jal   = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b10, 2'b10, 2'b10);
        m_jal   = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b11, 2'b11, 2'b11);
        v_jr    = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b00, 2'b00, 2'b11);
        v_jmp   = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b00, 2'b00, 2'b10);
        m_pc    = mk_sel(0, 0, 2'b00, 0, 4'd0, 0, 2'b00, 2'b00, 2'b11);
        v_add   = mk_sel(1, 0, 2'b00, 0, 4'd2, 0, 2'b00, 2'b00, 2'b00);
        v_sll   = mk_sel(1, 1, 2'b00, 0, 4'd5, 0, 2'b00, 2'b00, 2'b00);
        m_rex   = mk_sel(1, 1, 2'b11, 0, 4'hF, 0, 2'b00, 2'b00, 2'b00);
        v_ori   = mk_sel(0, 0, 2'b10, 1, 4'd1, 0, 2'b00, 2'b00, 2'b00);
        m_iex   = mk_sel(0, 0, 2'b11, 1, 4'hF, 0, 2'b00, 2'b00, 2'b00);

        rst = 1; clk_en = 1; mem_ready = 1; zero = 0; opcode = 6'h00; funct = 6'h00;
        @(posedge clk);
        #1;
        apply_stimulus(1, 1, 1, 0, 6'h00, 6'h00, ex(S_FETCH, 0, EN_NONE, 0, 0, v_fetch, M_ALL), "reset");

        // lw with memory always ready: five states, RegWrite only in MEMWB
        fetch_ok(6'h23, 0, "lw_fetch");
        decode_ok(6'h23, 0, "lw_decode");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMADR, 0, EN_NONE, 0, 0, v_madr, m_madr), "lw_memadr");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMRD, 1, EN_NONE, 0, 0, v_mem, v_mem), "lw_memrd");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMWB, 0, EN_RW, 0, 0, v_mwb, m_wb), "lw_memwb");

        // sw with three stalled cycles before mem_ready
        fetch_ok(6'h2B, 0, "sw_fetch");
        decode_ok(6'h2B, 0, "sw_decode");
        apply_stimulus(0, 1, 1, 0, 6'h2B, 0, ex(S_MEMADR, 0, EN_NONE, 0, 0, v_madr, m_madr), "sw_memadr");
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1, 0, 0, 6'h2B, 0, ex(S_MEMWR, 1, EN_NONE, 0, 0, v_mem, v_mem), "sw_stall");
        apply_stimulus(0, 1, 1, 0, 6'h2B, 0, ex(S_MEMWR, 1, EN_MW, 0, 0, v_mem, v_mem), "sw_write");

        for (int i = 0; i < 4; i++) begin
            fetch_ok(br_op[i], 0, "br_fetch");
            decode_ok(br_op[i], 0, "br_decode");
            apply_stimulus(0, 1, 1, br_z[i], br_op[i], 0,
                           ex(S_BRANCH, 0, br_en[i], 0, 0, v_br, m_br), "branch");
        end

        fetch_ok(6'h03, 0, "jal_fetch");
        decode_ok(6'h03, 0, "jal_decode");
        apply_stimulus(0, 1, 1, 0, 6'h03, 0, ex(S_JAL, 0, EN_JAL, 0, 0, v_jal, m_jal), "jal");

        fetch_ok(6'h00, 6'h20, "add_fetch");
        decode_ok(6'h00, 6'h20, "add_decode");
        apply_stimulus(0, 1, 1, 0, 6'h00, 6'h20, ex(S_REX, 0, EN_NONE, 0, 0, v_add, m_rex), "add_rex");
        apply_stimulus(0, 1, 1, 0, 6'h00, 6'h20, ex(S_RWB, 0, EN_RW, 0, 0, v_rwb, m_wb), "add_rwb");

        fetch_ok(6'h00, 6'h00, "sll_fetch");
        decode_ok(6'h00, 6'h00, "sll_decode");
        apply_stimulus(0, 1, 1, 0, 6'h00, 6'h00, ex(S_REX, 0, EN_NONE, 0, 0, v_sll, m_rex), "sll_rex");
        apply_stimulus(0, 1, 1, 0, 6'h00, 6'h00, ex(S_RWB, 0, EN_RW, 0, 0, v_rwb, m_wb), "sll_rwb");

        fetch_ok(6'h00, 6'h08, "jr_fetch");
        decode_ok(6'h00, 6'h08, "jr_decode");
        apply_stimulus(0, 1, 1, 0, 6'h00, 6'h08, ex(S_JR, 0, EN_PC, 0, 0, v_jr, m_pc), "jr");

        fetch_ok(6'h0D, 0, "ori_fetch");
        decode_ok(6'h0D, 0, "ori_decode");
        apply_stimulus(0, 1, 1, 0, 6'h0D, 0, ex(S_IEX, 0, EN_NONE, 0, 0, v_ori, m_iex), "ori_iex");
        apply_stimulus(0, 1, 1, 0, 6'h0D, 0, ex(S_IWB, 0, EN_RW, 0, 0, v_iwb, m_wb), "ori_iwb");

        fetch_ok(6'h02, 0, "j_fetch");
        decode_ok(6'h02, 0, "j_decode");
        apply_stimulus(0, 1, 1, 0, 6'h02, 0, ex(S_JUMP, 0, EN_PC, 0, 0, v_jmp, m_pc), "jump");

        fetch_ok(6'h3F, 0, "ill_fetch");
        apply_stimulus(0, 1, 1, 0, 6'h3F, 0, ex(S_DECODE, 0, EN_NONE, 1, 0, v_dec, m_dec), "ill_opcode");
        fetch_ok(6'h00, 6'h3F, "illfn_fetch");
        decode_ok(6'h00, 6'h3F, "illfn_decode");
        apply_stimulus(0, 1, 1, 0, 6'h00, 6'h3F, ex(S_REX, 0, EN_NONE, 1, 0, 16'h0, M_NONE), "ill_funct");

        // clk_en low freezes FETCH and MEMRD and suppresses the MEMWB write
        apply_stimulus(0, 0, 1, 0, 6'h23, 0, ex(S_FETCH, 1, EN_NONE, 0, 0, v_fetch, M_ALL), "ce_fetch_hold");
        fetch_ok(6'h23, 0, "ce_fetch");
        decode_ok(6'h23, 0, "ce_decode");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMADR, 0, EN_NONE, 0, 0, v_madr, m_madr), "ce_memadr");
        apply_stimulus(0, 1, 0, 0, 6'h23, 0, ex(S_MEMRD, 1, EN_NONE, 0, 0, v_mem, v_mem), "ce_memrd_wait");
        apply_stimulus(0, 0, 1, 0, 6'h23, 0, ex(S_MEMRD, 1, EN_NONE, 0, 0, v_mem, v_mem), "ce_memrd_frz1");
        apply_stimulus(0, 0, 1, 0, 6'h23, 0, ex(S_MEMRD, 1, EN_NONE, 0, 0, v_mem, v_mem), "ce_memrd_frz2");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMRD, 1, EN_NONE, 0, 0, v_mem, v_mem), "ce_memrd_go");
        apply_stimulus(0, 0, 1, 0, 6'h23, 0, ex(S_MEMWB, 0, EN_NONE, 0, 0, v_mwb, m_wb), "ce_memwb_frz");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMWB, 0, EN_RW, 0, 0, v_mwb, m_wb), "ce_memwb");

        // reset while a store is waiting: no MemWrite, request drops
        fetch_ok(6'h2B, 0, "rst_fetch");
        decode_ok(6'h2B, 0, "rst_decode");
        apply_stimulus(0, 1, 1, 0, 6'h2B, 0, ex(S_MEMADR, 0, EN_NONE, 0, 0, v_madr, m_madr), "rst_memadr");
        apply_stimulus(0, 1, 0, 0, 6'h2B, 0, ex(S_MEMWR, 1, EN_NONE, 0, 0, v_mem, v_mem), "rst_memwr_wait");
        apply_stimulus(1, 1, 1, 0, 6'h2B, 0, ex(S_MEMWR, 0, EN_NONE, 0, 0, 16'h0, M_NONE), "rst_mid_write");
        fetch_ok(6'h23, 0, "rst_after");

        // timeout: four unready FETCH cycles then sticky ERR until reset
        decode_ok(6'h23, 0, "to_decode");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMADR, 0, EN_NONE, 0, 0, v_madr, m_madr), "to_memadr");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMRD, 1, EN_NONE, 0, 0, v_mem, v_mem), "to_memrd");
        apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_MEMWB, 0, EN_RW, 0, 0, v_mwb, m_wb), "to_memwb");
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 1, 0, 0, 6'h23, 0, ex(S_FETCH, 1, EN_NONE, 0, 0, v_fetch, M_ALL), "to_wait");
        for (int i = 0; i < 2; i++)
            apply_stimulus(0, 1, 1, 0, 6'h23, 0, ex(S_ERR, 0, EN_NONE, 0, 1, 16'h0, M_NONE), "to_err_sticky");
        apply_stimulus(1, 1, 1, 0, 6'h23, 0, ex(S_ERR, 0, EN_NONE, 0, 1, 16'h0, M_NONE), "to_err_rst");
        fetch_ok(6'h23, 0, "to_recovered");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
